// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width,
// and bit-counter sizing.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must index 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_bit_cell.sv
// One-bit full adder reused every cycle by the serial subtractor.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: difference = a + ~b + 1, LSB first,
// one bit per clock behind a start/busy/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             carryout,
    output logic             overflow
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_d, ov_d, busy_d, done_d;
    logic             accept;
    logic             sum_c, cout_c;

    sub_bit_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (sum_c),
        .cout (cout_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            carryout   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            busy       <= busy_d;
            done       <= done_d;
            difference <= diff_d;
            carryout   <= co_d;
            overflow   <= ov_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        diff_d  = difference;
        co_d    = carryout;
        ov_d    = overflow;
        accept  = start && (state_q == IDLE || state_q == DONE);

        unique case (state_q)
            IDLE: ;
            RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = {sum_c, res_q[WIDTH-1:1]};
                carry_d = cout_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB
                    diff_d  = {sum_c, res_q[WIDTH-1:1]};
                    co_d    = cout_c;
                    ov_d    = carry_q ^ cout_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = ~b;
            res_d   = '0;
            carry_d = 1'b1;
            cnt_d   = '0;
            state_d = RUN;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed/scoreboard bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] a, b;
    logic         busy, done, carryout, overflow;
    logic [W-1:0] difference;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .carryout   (carryout),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t m;
        logic [W:0] s;
        s      = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        m.diff = s[W-1:0];
        m.co   = s[W];
        m.ov   = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
        return m;
    endfunction

    task automatic push(input logic [W-1:0] d, input logic co, input logic ov);
        exp_t e;
        e.diff = d;
        e.co   = co;
        e.ov   = ov;
        sb.push_back(e);
    endtask

    // Present operands with start at a falling edge; returns at the accepting edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
    endtask

    // mode 0: drop start; mode 1: pulse start with gx/gy mid-RUN; mode 2: hold start with gx/gy.
    task automatic wait_done(input string tag, input int mode, input logic [W-1:0] gx,
                             input logic [W-1:0] gy, output int lat);
        int           busy_n;
        bit           held;
        logic [W-1:0] d0;
        exp_t         e;
        lat    = 0;
        busy_n = 0;
        held   = 1'b1;
        d0     = '0;
        while (lat <= int'(W) + 2) begin
            @(negedge clk);
            if (mode == 0) begin
                start = 1'b0;
            end else if (mode == 1) begin
                start = (lat == 1);
                a     = gx;
                b     = gy;
            end else begin
                a = gx;
                b = gy;
            end
            if (lat == 0) d0 = difference;
            if (done) break;
            busy_n += int'(busy);
            if (difference !== d0) held = 1'b0;
            lat++;
        end
        chk({tag, "_done"}, 32'(done), 32'(1));
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
        chk({tag, "_hold_in_run"}, 32'(held), 32'(1));
        chk({tag, "_busy_in_done"}, 32'(busy), 32'(0));
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, "_difference"}, 32'(difference), 32'(e.diff));
            chk({tag, "_carryout"}, 32'(carryout), 32'(e.co));
            chk({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
        end
    endtask

    task automatic after_done(input string tag);
        logic [W-1:0] d;
        d = difference;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'(0));
        chk({tag, "_result_hold"}, 32'(difference), 32'(d));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_difference"}, 32'(difference), 32'(0));
        chk({tag, "_carryout"}, 32'(carryout), 32'(0));
        chk({tag, "_overflow"}, 32'(overflow), 32'(0));
        chk({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        int   lat1, lat2;
        bit   saw_done;
        logic [W-1:0] rx, ry;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_zero("reset");

        // 4 - 2
        push(4'b0010, 1'b1, 1'b0);
        launch(4'b0100, 4'b0010);
        wait_done("t1", 0, '0, '0, lat1);
        after_done("t1");

        // 3 - 7
        push(4'b1100, 1'b0, 1'b0);
        launch(4'b0011, 4'b0111);
        wait_done("t2", 0, '0, '0, lat1);
        after_done("t2");

        // 7 - (-8)
        push(4'b1111, 1'b0, 1'b1);
        launch(4'b0111, 4'b1000);
        wait_done("t3", 0, '0, '0, lat1);
        after_done("t3");

        // -6 - 3 with start held, then 0 - 0 issued back-to-back from DONE
        push(4'b0111, 1'b1, 1'b1);
        launch(4'b1010, 4'b0011);
        wait_done("t4", 2, 4'b0000, 4'b0000, lat1);
        push(4'b0000, 1'b1, 1'b0);
        @(posedge clk);
        wait_done("t4b", 0, '0, '0, lat2);
        chk("t4b_done_gap", 32'(lat2 + 1), 32'(5));
        after_done("t4b");

        // start with new operands mid-RUN is ignored
        push(4'b0100, 1'b1, 1'b0);
        launch(4'b0101, 4'b0001);
        wait_done("t5", 1, 4'b1111, 4'b0110, lat1);
        after_done("t5");

        // reset during the second RUN cycle discards the operation
        launch(4'b0110, 4'b0001);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_zero("t6_reset");
        saw_done = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("t6_no_done", 32'(saw_done), 32'(0));
        push(4'b0101, 1'b1, 1'b0);
        launch(4'b0110, 4'b0001);
        wait_done("t6b", 0, '0, '0, lat1);
        after_done("t6b");

        // Pseudo-random operands against the arithmetic model
        for (int i = 0; i < 4; i++) begin
            rx = W'($urandom_range(0, (1 << W) - 1));
            ry = W'($urandom_range(0, (1 << W) - 1));
            sb.push_back(model(rx, ry));
            launch(rx, ry);
            wait_done("rnd", 0, '0, '0, lat1);
        end

        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
